// File: rtl/climber_pkg.sv
// Shared definitions for the climber pipeline: game state encoding, info-bus
// field offsets and the default height-counter width.
//
// Info bus layout (69 bits, MSB first):
//   {gamereset, hcount[10:0], vcount[9:0], hsync, vsync, blank,
//    hand1x[10:0], hand1y[9:0], hand2x[10:0], hand2y[9:0], grab2, grab1}
package climber_pkg;

  localparam int unsigned HEIGHT_W_DEFAULT = 16;

  localparam int unsigned INFO_W         = 69;
  localparam int unsigned Y_W            = 10;
  localparam int unsigned INFO_GRAB1     = 0;
  localparam int unsigned INFO_GRAB2     = 1;
  localparam int unsigned INFO_HAND2Y    = 2;   // lsb of hand2y[9:0]
  localparam int unsigned INFO_HAND1Y    = 23;  // lsb of hand1y[9:0]
  localparam int unsigned INFO_VSYNC     = 45;
  localparam int unsigned INFO_GAMERESET = 68;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClimb = 2'd1,
    StFall  = 2'd2,
    StWin   = 2'd3
  } climb_state_e;

endpackage

// File: rtl/climb_delta.sv
// Combinational per-frame climb computation.
// A hand contributes its vertical delta only if it is grabbed now and was
// grabbed on the previous frame. Valid deltas are averaged (floor), then the
// result is clamped to +/-MAX_STEP.
//
// Ports:
//   g1, g2     grab flags this frame
//   pg1, pg2   grab flags previous frame
//   y1, y2     hand y this frame
//   py1, py2   hand y previous frame
//   climb      signed clamped climb delta (positive = climber rises)
module climb_delta
  import climber_pkg::*;
#(
  parameter int unsigned MAX_STEP = 32
) (
  input  logic                  g1,
  input  logic                  g2,
  input  logic                  pg1,
  input  logic                  pg2,
  input  logic [Y_W-1:0]        y1,
  input  logic [Y_W-1:0]        y2,
  input  logic [Y_W-1:0]        py1,
  input  logic [Y_W-1:0]        py2,
  output logic signed [Y_W:0]   climb
);

  localparam logic signed [Y_W:0] StepMax = (Y_W + 1)'(MAX_STEP);
  localparam logic signed [Y_W:0] StepMin = -StepMax;

  logic                  v1, v2;
  logic signed [Y_W:0]   d1, d2, avg, raw;
  logic signed [Y_W+1:0] sum;
  logic                  unused_sum_lsb;

  assign v1 = g1 & pg1;
  assign v2 = g2 & pg2;

  assign d1 = v1 ? $signed({1'b0, y1}) - $signed({1'b0, py1}) : '0;
  assign d2 = v2 ? $signed({1'b0, y2}) - $signed({1'b0, py2}) : '0;

  // Dropping the lsb of the sign-extended sum is an arithmetic shift (floor).
  assign sum            = {d1[Y_W], d1} + {d2[Y_W], d2};
  assign avg            = sum[Y_W+1:1];
  assign unused_sum_lsb = sum[0];

  always_comb begin
    raw = '0;
    if (v1 && v2) begin
      raw = avg;
    end else if (v1) begin
      raw = d1;
    end else if (v2) begin
      raw = d2;
    end

    climb = raw;
    if (raw > StepMax) begin
      climb = StepMax;
    end else if (raw < StepMin) begin
      climb = StepMin;
    end
  end

endmodule

// File: rtl/climb_scroll.sv
// Climb/scroll stage downstream of the grab detector. Once per frame (vsync
// rising edge) converts grabbed-hand motion into climber height and runs the
// IDLE/CLIMB/FALL/WIN game FSM. Info bus and exists flag pass through with one
// clock of latency.
//
// Ports:
//   clockin     pixel clock
//   reset       asynchronous active-low reset
//   infoin      69-bit info bus (see climber_pkg)
//   existsin    pixel-is-hold flag
//   infout      infoin delayed one clock
//   existsout   existsin delayed one clock
//   clockout    clockin passed straight through
//   scroll      climber height / wall offset
//   height_max  best height this game
//   state       0 IDLE, 1 CLIMB, 2 FALL, 3 WIN
//   frame_tick  one-cycle pulse when a frame's results are valid
//
// Optional: define CLIMB_STAMINA_EN to force a fall after STAMINA_FRAMES
// CLIMB frames without upward progress, followed by a grab lockout until both
// hands are seen released.
module climb_scroll
  import climber_pkg::*;
#(
  parameter int unsigned HEIGHT_W       = HEIGHT_W_DEFAULT,
  parameter int unsigned MAX_STEP       = 32,
  parameter int unsigned GRAVITY        = 1,
  parameter int unsigned VMAX           = 24,
  parameter int unsigned NOGRAB_FRAMES  = 4,
  parameter int unsigned TOP_HEIGHT     = 4000,
  parameter int unsigned STAMINA_FRAMES = 300
) (
  input  logic                clockin,
  input  logic                reset,
  input  logic [INFO_W-1:0]   infoin,
  input  logic                existsin,
  output logic [INFO_W-1:0]   infout,
  output logic                existsout,
  output logic                clockout,
  output logic [HEIGHT_W-1:0] scroll,
  output logic [HEIGHT_W-1:0] height_max,
  output logic [1:0]          state,
  output logic                frame_tick
);

  localparam int unsigned NG_W  = $clog2(NOGRAB_FRAMES + 1);
  localparam int unsigned VEL_W = $clog2(VMAX + GRAVITY + 1);

  climb_state_e          state_q, state_d;
  logic [HEIGHT_W-1:0]   scroll_q, scroll_d;
  logic [HEIGHT_W-1:0]   hmax_q, hmax_d;
  logic [VEL_W-1:0]      vel_q, vel_d;
  logic [NG_W-1:0]       nograb_q, nograb_d;
  logic [Y_W-1:0]        py1_q, py1_d, py2_q, py2_d;
  logic                  pg1_q, pg1_d, pg2_q, pg2_d;
  logic                  vsync_q;
  logic                  tick_q, tick_d;

  logic                  vsync, tick, gamereset;
  logic                  g1, g2, any_grab, force_fall;
  logic [Y_W-1:0]        y1, y2;
  logic signed [Y_W:0]   climb;
  logic signed [HEIGHT_W+1:0] climb_sum;
  logic [HEIGHT_W-1:0]   climb_scroll_sat, fall_scroll_sat;
  logic [VEL_W-1:0]      vel_sum, vel_next;
  logic [NG_W-1:0]       nograb_inc;

  assign clockout  = clockin;
  assign vsync     = infoin[INFO_VSYNC];
  assign gamereset = infoin[INFO_GAMERESET];
  assign tick      = vsync & ~vsync_q;
  assign y1        = infoin[INFO_HAND1Y +: Y_W];
  assign y2        = infoin[INFO_HAND2Y +: Y_W];

`ifdef CLIMB_STAMINA_EN
  localparam int unsigned ST_W = $clog2(STAMINA_FRAMES + 1);
  logic [ST_W-1:0] stam_q, stam_d;
  logic            lock_q, lock_d;
  // While locked out after a stamina release, grabs are invisible to the FSM.
  assign g1 = infoin[INFO_GRAB1] & ~lock_q;
  assign g2 = infoin[INFO_GRAB2] & ~lock_q;
`else
  localparam int unsigned UnusedStaminaFrames = STAMINA_FRAMES;
  assign g1 = infoin[INFO_GRAB1];
  assign g2 = infoin[INFO_GRAB2];
`endif

  assign any_grab = g1 | g2;

  climb_delta #(
    .MAX_STEP (MAX_STEP)
  ) u_climb_delta (
    .g1    (g1),
    .g2    (g2),
    .pg1   (pg1_q),
    .pg2   (pg2_q),
    .y1    (y1),
    .y2    (y2),
    .py1   (py1_q),
    .py2   (py2_q),
    .climb (climb)
  );

  // Saturating scroll arithmetic; the two guard bits catch under/overflow.
  always_comb begin
    climb_sum = $signed({2'b00, scroll_q}) + (HEIGHT_W + 2)'(climb);
    if (climb_sum[HEIGHT_W+1]) begin
      climb_scroll_sat = '0;
    end else if (climb_sum[HEIGHT_W]) begin
      climb_scroll_sat = '1;
    end else begin
      climb_scroll_sat = climb_sum[HEIGHT_W-1:0];
    end

    vel_sum  = vel_q + VEL_W'(GRAVITY);
    vel_next = (vel_sum > VEL_W'(VMAX)) ? VEL_W'(VMAX) : vel_sum;
    if (HEIGHT_W'(vel_next) >= scroll_q) begin
      fall_scroll_sat = '0;
    end else begin
      fall_scroll_sat = scroll_q - HEIGHT_W'(vel_next);
    end

    nograb_inc = nograb_q + NG_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    scroll_d   = scroll_q;
    hmax_d     = hmax_q;
    vel_d      = vel_q;
    nograb_d   = nograb_q;
    py1_d      = py1_q;
    py2_d      = py2_q;
    pg1_d      = pg1_q;
    pg2_d      = pg2_q;
    tick_d     = 1'b0;
    force_fall = 1'b0;
`ifdef CLIMB_STAMINA_EN
    stam_d     = stam_q;
    lock_d     = lock_q;
`endif

    if (gamereset) begin
      state_d  = StIdle;
      scroll_d = '0;
      hmax_d   = '0;
      vel_d    = '0;
      nograb_d = '0;
`ifdef CLIMB_STAMINA_EN
      stam_d   = '0;
      lock_d   = 1'b0;
`endif
    end else if (tick) begin
      tick_d = 1'b1;
      py1_d  = y1;
      py2_d  = y2;
      pg1_d  = g1;
      pg2_d  = g2;
`ifdef CLIMB_STAMINA_EN
      if (!infoin[INFO_GRAB1] && !infoin[INFO_GRAB2]) begin
        lock_d = 1'b0;
      end
`endif

      unique case (state_q)
        StIdle: begin
          scroll_d = '0;
          nograb_d = '0;
          if (any_grab) begin
            state_d = StClimb;
          end
        end

        StClimb: begin
          scroll_d = climb_scroll_sat;
          nograb_d = any_grab ? '0 : nograb_inc;
          if (!any_grab && (nograb_inc == NG_W'(NOGRAB_FRAMES))) begin
            force_fall = 1'b1;
          end
`ifdef CLIMB_STAMINA_EN
          stam_d = (climb > 0) ? '0 : stam_q + ST_W'(1);
          if ((climb <= 0) && (stam_q + ST_W'(1) == ST_W'(STAMINA_FRAMES))) begin
            force_fall = 1'b1;
            lock_d     = 1'b1;
          end
`endif
          if (climb_scroll_sat >= HEIGHT_W'(TOP_HEIGHT)) begin
            state_d = StWin;
          end else if (force_fall) begin
            state_d  = StFall;
            vel_d    = '0;
            nograb_d = '0;
`ifdef CLIMB_STAMINA_EN
            stam_d   = '0;
`endif
          end
        end

        StFall: begin
          if (any_grab) begin
            // Re-grab catches the climber in place.
            state_d  = StClimb;
            vel_d    = '0;
            nograb_d = '0;
          end else begin
            vel_d    = vel_next;
            scroll_d = fall_scroll_sat;
            if (fall_scroll_sat == '0) begin
              state_d = StIdle;
            end
          end
        end

        StWin: begin
          scroll_d = scroll_q;
        end

        default: begin
          state_d = StIdle;
        end
      endcase

      if (scroll_d > hmax_q) begin
        hmax_d = scroll_d;
      end
    end
  end

  always_ff @(posedge clockin or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      scroll_q <= '0;
      hmax_q   <= '0;
      vel_q    <= '0;
      nograb_q <= '0;
      py1_q    <= '0;
      py2_q    <= '0;
      pg1_q    <= 1'b0;
      pg2_q    <= 1'b0;
      tick_q   <= 1'b0;
      // Held high so a vsync already high at release does not count as an edge.
      vsync_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      scroll_q <= scroll_d;
      hmax_q   <= hmax_d;
      vel_q    <= vel_d;
      nograb_q <= nograb_d;
      py1_q    <= py1_d;
      py2_q    <= py2_d;
      pg1_q    <= pg1_d;
      pg2_q    <= pg2_d;
      tick_q   <= tick_d;
      vsync_q  <= vsync;
    end
  end

`ifdef CLIMB_STAMINA_EN
  always_ff @(posedge clockin or negedge reset) begin
    if (!reset) begin
      stam_q <= '0;
      lock_q <= 1'b0;
    end else begin
      stam_q <= stam_d;
      lock_q <= lock_d;
    end
  end
`endif

  always_ff @(posedge clockin or negedge reset) begin
    if (!reset) begin
      infout    <= '0;
      existsout <= 1'b0;
    end else begin
      infout    <= infoin;
      existsout <= existsin;
    end
  end

  assign scroll     = scroll_q;
  assign height_max = hmax_q;
  assign state      = state_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_climb_scroll.sv
module tb_climb_scroll;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLIMB = 2'd1;
  localparam logic [1:0] S_FALL  = 2'd2;
  localparam logic [1:0] S_WIN   = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [68:0] infoin;
  logic        existsin;
  logic [68:0] infout;
  logic        existsout;
  logic        clockout;
  logic [15:0] scroll;
  logic [15:0] height_max;
  logic [1:0]  state;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int ticks_seen = 0;
  int frame_id = 0;
  logic sb_off = 1'b0;

  typedef struct packed {
    int          id;
    logic [15:0] s;
    logic [15:0] h;
    logic [1:0]  st;
  } exp_t;
  exp_t sb_q[$];

  logic [68:0] exp_info;
  logic        exp_exists;

  climb_scroll u_dut (
    .clockin    (clk),
    .reset      (rst_n),
    .infoin     (infoin),
    .existsin   (existsin),
    .infout     (infout),
    .existsout  (existsout),
    .clockout   (clockout),
    .scroll     (scroll),
    .height_max (height_max),
    .state      (state),
    .frame_tick (frame_tick)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Scoreboard monitor: every frame_tick pops one expected frame result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && frame_tick) begin
      ticks_seen++;
      if (!sb_off) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tick: got tick expected none at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("f%0d_scroll", e.id), 32'(scroll), 32'(e.s));
          chk($sformatf("f%0d_hmax", e.id), 32'(height_max), 32'(e.h));
          chk($sformatf("f%0d_state", e.id), 32'(state), 32'(e.st));
        end
      end
    end
  end

  // Pass-through reference: input delayed one clock, zero in reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_info   <= '0;
      exp_exists <= 1'b0;
    end else begin
      exp_info   <= infoin;
      exp_exists <= existsin;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (infout !== exp_info || existsout !== exp_exists) begin
      errors++;
      $display("FAIL passthru: got %h/%b expected %h/%b", infout, existsout, exp_info,
               exp_exists);
    end
  end

  // One frame: vsync low with the new hand data, then vsync rises (tick).
  task automatic frame(input logic g1, input logic g2, input int y1, input int y2,
                       input int es, input int eh, input logic [1:0] est);
    logic [68:0] v;
    exp_t e;
    v = '0;
    v[0]       = g1;
    v[1]       = g2;
    v[2 +: 10] = 10'(y2);
    v[23 +: 10] = 10'(y1);
    v[12 +: 11] = 11'($urandom());
    v[33 +: 11] = 11'($urandom());
    @(posedge clk); #1;
    infoin   = v;
    existsin = 1'($urandom());
    @(posedge clk); #1;
    infoin[45] = 1'b1;
    frame_id++;
    e.id = frame_id;
    e.s  = 16'(es);
    e.h  = 16'(eh);
    e.st = est;
    sb_q.push_back(e);
    repeat (3) @(posedge clk);
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_scroll"}, 32'(scroll), 32'd0);
    chk({pfx, "_hmax"}, 32'(height_max), 32'd0);
    chk({pfx, "_state"}, 32'(state), 32'(S_IDLE));
    chk({pfx, "_tick"}, 32'(frame_tick), 32'd0);
    chk({pfx, "_existsout"}, 32'(existsout), 32'd0);
    chk({pfx, "_infout_or"}, 32'(|infout), 32'd0);
  endtask

  initial begin
    int es;
    int t0;
    int y;
    logic win;
    logic [68:0] v;

    infoin   = '0;
    existsin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("por");
    chk("clockout", 32'(clockout), 32'(clk));
    rst_n = 1'b1;

    // Single-hand climb.
    frame(1, 0, 100, 0, 0, 0, S_CLIMB);
    frame(1, 0, 110, 0, 10, 10, S_CLIMB);
    frame(1, 0, 120, 0, 20, 20, S_CLIMB);
    // Two-hand average, floor on negatives, clamps.
    frame(1, 1, 120, 200, 20, 20, S_CLIMB);
    frame(1, 1, 125, 206, 25, 25, S_CLIMB);   // (5+6)>>>1 = 5
    frame(1, 1, 120, 200, 19, 25, S_CLIMB);   // (-5-6)>>>1 = -6
    frame(1, 0, 180, 200, 51, 51, S_CLIMB);   // +60 -> 32
    frame(1, 0, 100, 200, 19, 51, S_CLIMB);   // -80 -> -32
    frame(1, 0, 131, 200, 50, 51, S_CLIMB);
    // Four no-grab frames, then gravity down to IDLE.
    frame(0, 0, 131, 200, 50, 51, S_CLIMB);
    frame(0, 0, 131, 200, 50, 51, S_CLIMB);
    frame(0, 0, 131, 200, 50, 51, S_CLIMB);
    frame(0, 0, 131, 200, 50, 51, S_FALL);
    es = 50;
    for (int v_ = 1; v_ <= 10; v_++) begin
      es = (v_ >= es) ? 0 : es - v_;
      frame(0, 0, 131, 200, es, 51, (es == 0) ? S_IDLE : S_FALL);
    end
    // Re-grab during fall.
    frame(1, 0, 131, 200, 0, 51, S_CLIMB);
    frame(1, 0, 160, 200, 29, 51, S_CLIMB);
    frame(0, 0, 160, 200, 29, 51, S_CLIMB);
    frame(0, 0, 160, 200, 29, 51, S_CLIMB);
    frame(0, 0, 160, 200, 29, 51, S_CLIMB);
    frame(0, 0, 160, 200, 29, 51, S_FALL);
    frame(0, 0, 160, 200, 28, 51, S_FALL);
    frame(0, 0, 160, 200, 26, 51, S_FALL);
    frame(1, 0, 160, 200, 26, 51, S_CLIMB);   // caught, no scroll change
    frame(1, 0, 170, 200, 36, 51, S_CLIMB);
    frame(0, 0, 170, 200, 36, 51, S_CLIMB);
    frame(0, 0, 170, 200, 36, 51, S_CLIMB);
    frame(0, 0, 170, 200, 36, 51, S_CLIMB);
    frame(0, 0, 170, 200, 36, 51, S_FALL);
    frame(0, 0, 170, 200, 35, 51, S_FALL);    // velocity restarted at 1
    frame(1, 0, 0, 200, 35, 51, S_CLIMB);

    // Climb to the top in clamped +32 steps, releasing to rewind the hand.
    es  = 35;
    win = 1'b0;
    y   = 0;
    while (!win) begin
      for (int s = 1; s <= 15 && !win; s++) begin
        y  = 64 * s;
        es = es + 32;
        win = (es >= 4000);
        frame(1, 0, y, 200, es, imax(51, es), win ? S_WIN : S_CLIMB);
      end
      if (!win) begin
        frame(0, 0, y, 200, es, imax(51, es), S_CLIMB);
        y = 0;
        frame(1, 0, 0, 200, es, imax(51, es), S_CLIMB);
      end
    end
    frame(1, 0, y + 64, 200, es, es, S_WIN);
    frame(1, 0, y + 128, 200, es, es, S_WIN);

    // Gamereset pulse, no tick.
    @(posedge clk); #1;
    infoin[68] = 1'b1;
    @(posedge clk); #1;
    infoin[68] = 1'b0;
    @(negedge clk);
    chk("grst_scroll", 32'(scroll), 32'd0);
    chk("grst_hmax", 32'(height_max), 32'd0);
    chk("grst_state", 32'(state), 32'(S_IDLE));

    frame(1, 0, 500, 200, 0, 0, S_CLIMB);
    frame(1, 0, 510, 200, 10, 10, S_CLIMB);

    // Asynchronous reset with vsync still high.
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    t0 = ticks_seen;
    repeat (6) @(posedge clk);
    #1;
    chk("no_tick_after_release", 32'(ticks_seen - t0), 32'd0);
    chk("state_after_release", 32'(state), 32'(S_IDLE));
    frame(1, 0, 520, 200, 0, 0, S_CLIMB);
    repeat (2) @(posedge clk);
    chk("pending_frames", 32'(sb_q.size()), 32'd0);

    // Random pass-through traffic; FSM results ignored here.
    sb_off = 1'b1;
    repeat (200) begin
      @(posedge clk); #1;
      v[31:0]  = $urandom();
      v[63:32] = $urandom();
      v[68:64] = 5'($urandom());
      infoin   = v;
      existsin = 1'($urandom());
    end
    @(negedge clk);
    chk("clockout_low", 32'(clockout), 32'(clk));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/climb_scroll.md
Name: climb_scroll

Overview:
- Pipeline stage directly downstream of the hand/hold grab stage.
- Consumes the 69-bit info bus, whose bits [1:0] carry per-frame confirmed grabs.
- Once per frame, converts hand motion while grabbing into climber height (wall scroll offset) and runs the climb/fall/win game FSM.
- Forwards the bus, exists and clock to the renderer with 1-cycle latency.

Parameters:
- HEIGHT_W, 16, width of scroll/height counters
- MAX_STEP, 32, max absolute per-frame climb delta, in pixels
- GRAVITY, 1, fall velocity increment per frame
- VMAX, 24, fall velocity ceiling
- NOGRAB_FRAMES, 4, consecutive no-grab frames before FALL
- TOP_HEIGHT, 4000, scroll value that triggers WIN
- STAMINA_FRAMES, 300, frames of hanging without net climb before forced release (optional feature only)

Ports:
- clockin  in  1  pixel clock (65 MHz); the only clock
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- infoin  in  69  {gamereset, hcount[10:0], vcount[9:0], hsync, vsync, blank, hand1x[10:0], hand1y[9:0], hand2x[10:0], hand2y[9:0], grab2, grab1}
- existsin  in  1  pixel-is-hold flag
- infout  out  69  infoin delayed 1 clock
- existsout  out  1  existsin delayed 1 clock
- clockout  out  1  = clockin, combinational
- scroll  out  HEIGHT_W  current climber height / wall offset
- height_max  out  HEIGHT_W  best height this game
- state  out  2  0 IDLE, 1 CLIMB, 2 FALL, 3 WIN
- frame_tick  out  1  1-cycle pulse on processed frame

Behaviour:
- Reset values: infout 0, existsout 0, scroll 0, height_max 0, state IDLE, frame_tick 0. All internal state (velocity, prev_y, prev_grab, no-grab counter) also resets to 0.
- Frame tick is synchronous: vsync is registered, and a tick occurs on the cycle where vsync=1 and the previous sample was 0. No logic is clocked from vsync.
- On a tick, sample g1, g2, y1, y2 from infoin. All FSM/arithmetic updates happen on that cycle; frame_tick is high on the following cycle with outputs valid.
- Per-hand delta (11-bit signed): d = y_cur − prev_y. It counts only if the hand is grabbed this frame and was grabbed last frame; otherwise it is 0.
- climb = average of the valid deltas:
  - both hands valid: (d1+d2)>>>1, arithmetic shift, rounds toward −inf
  - one hand valid: that delta
  - no hand valid: 0
- climb is clamped to [−MAX_STEP, +MAX_STEP]. Downward hand motion (y increasing) raises the climber.
- Scroll update saturates at 0 and 2^HEIGHT_W−1. No wrap-around.
- prev_y and prev_grab update every tick, regardless of state.
- FSM transitions:
  - IDLE: scroll held at 0. Any grab → CLIMB.
  - CLIMB: scroll += climb. A grab resets the no-grab counter; a no-grab frame increments it. Counter reaching NOGRAB_FRAMES → FALL, velocity = 0. scroll ≥ TOP_HEIGHT → WIN; WIN takes priority over FALL in the same frame.
  - FALL: velocity = min(velocity+GRAVITY, VMAX), then scroll −= velocity (saturating). Any grab → CLIMB with velocity cleared and the counter cleared; no scroll change in that frame. scroll reaching 0 → IDLE.
  - WIN: scroll frozen; remains until reset or gamereset.
- height_max = max(height_max, scroll), updated on each tick; cleared in IDLE entered via gamereset.
- gamereset (infoin[68]=1) is a synchronous game reset, sampled every cycle (not only on ticks). It forces IDLE, scroll 0, height_max 0, velocity 0. It has priority over tick processing in the same cycle.
- Asynchronous reset mid-frame: the first tick after release still requires a fresh vsync rising edge.
- Pass-through: infout and existsout are registered every clock, independent of the FSM.

Optional Feature:
- Macro: CLIMB_STAMINA_EN.
- When defined, a stamina counter increments on each CLIMB tick where climb ≤ 0, and clears on any climb > 0.
  - Reaching STAMINA_FRAMES forces FALL even if a hand is grabbed.
  - Grabs are then ignored until both grab bits have been seen 0 on at least one tick.
- When undefined, there is no counter or lockout, and behaviour is exactly as above.

Decomposition:
- Shared package climber_pkg:
  - state encoding constants (IDLE/CLIMB/FALL/WIN)
  - info-bus field offsets (INFO_GRAB1=0, INFO_GRAB2=1, hand y fields, INFO_VSYNC, INFO_GAMERESET=68)
  - HEIGHT_W default
- Sub-module: climb_delta, combinational. Computes per-hand valid deltas, the average and the clamp. It is reused by the renderer's hand-trail logic.

Test Plan:
- Reset: hold reset=0 mid-stream → all outputs 0 and state IDLE; after release, no tick until the next vsync 0→1.
- Single-hand climb: grab1=1 over 3 frames with y1 = 100, 110, 120 → scroll 0, 10, 20; state CLIMB from the first frame.
- Two-hand average and clamp: both grabbed, y1 100→105, y2 200→206 → climb 5 (floor 5.5). Then y1 +60 with hand 2 released → climb clamped to 32.
- Fall: from scroll 50, no grabs for 4 frames → FALL. Velocities 1, 2, 3… subtract, reaching 0 → IDLE. Re-grab during fall → CLIMB with scroll unchanged that frame.
- Win and gamereset: drive scroll past 4000 → state WIN, scroll frozen. Pulse infoin[68] for 1 clock → IDLE, scroll=0, height_max=0.
- Pass-through: random infoin/existsin → infout/existsout equal the input delayed exactly 1 clock, every cycle.
